// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op encoding,
// default latencies, the result record and the arithmetic-op predicate.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MFHI  = 3'd6;
    localparam logic [2:0] MD_MFLO  = 3'd7;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_zero;
    } md_result_t;

    function automatic logic md_is_arith(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage / hazard-unit side of the multiply/divide controller.
interface muldiv_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_D;
    logic [31:0] rdata;

    modport master (
        output start, op, rs_val, rt_val, md_use_D,
        input  busy, stall_D, rdata
    );

    modport slave (
        input  start, op, rs_val, rt_val, md_use_D,
        output busy, stall_D, rdata
    );

endinterface

// File: rtl/muldiv_ctrl_compute.sv
// Combinational multiply/divide datapath producing the pending {HI, LO}
// result for the controller; one magnitude divider serves DIV and DIVU.
module muldiv_compute
    import muldiv_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output md_result_t  res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};

        signed_div = (op == MD_DIV);
        neg_q      = signed_div & (rs_val[31] ^ rt_val[31]);
        neg_r      = signed_div & rs_val[31];
        a_mag      = neg_r ? (32'd0 - rs_val) : rs_val;
        b_mag      = (signed_div & rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        // Guarding the divisor keeps a zero divide from producing X; the
        // result is discarded anyway via div_zero.
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = neg_q ? (32'd0 - q_mag) : q_mag;
        rem        = neg_r ? (32'd0 - r_mag) : r_mag;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        res = '0;
        case (op)
            MD_MULT: begin
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res.hi       = rem;
                res.lo       = quot;
                res.div_zero = (rt_val == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: owns HI/LO, models fixed latency with a busy
// countdown, and drives the D-stage stall and the mfhi/mflo read value.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_result_t  res;
    md_state_e   state;

    logic [CNT_W-1:0] cnt,  cnt_d;
    logic [31:0]      hi,   hi_d;
    logic [31:0]      lo,   lo_d;
    logic [31:0]      hi_p, hi_p_d;
    logic [31:0]      lo_p, lo_p_d;
    logic             dz,   dz_d;

    muldiv_compute u_compute (
        .op     (bus.op),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .res    (res)
    );

    assign state = (cnt != '0) ? MD_RUN : MD_IDLE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: HI/LO are plain registers, so all of them are reset; nothing here relies on power-up values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            hi_p <= '0;
            lo_p <= '0;
            dz   <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            hi   <= hi_d;
            lo   <= lo_d;
            hi_p <= hi_p_d;
            lo_p <= lo_p_d;
            dz   <= dz_d;
        end
    end

    always_comb begin
        cnt_d  = cnt;
        hi_d   = hi;
        lo_d   = lo;
        hi_p_d = hi_p;
        lo_p_d = lo_p;
        dz_d   = dz;
        case (state)
            MD_IDLE: begin
                if (bus.start) begin
                    if (md_is_arith(bus.op)) begin
                        hi_p_d = res.hi;
                        lo_p_d = res.lo;
                        dz_d   = res.div_zero;
                        cnt_d  = (bus.op == MD_MULT || bus.op == MD_MULTU) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    end else if (bus.op == MD_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.op == MD_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            MD_RUN: begin
                // Issues arriving while busy are dropped; only the countdown advances.
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1) && !dz) begin
                    hi_d = hi_p;
                    lo_d = lo_p;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy    = (state == MD_RUN);
        bus.stall_D = bus.md_use_D & (bus.busy | (bus.start & md_is_arith(bus.op)));
        case (bus.op)
            MD_MFHI: bus.rdata = hi;
            MD_MFLO: bus.rdata = lo;
            default: bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: latency, arithmetic corner
// cases, move-to/from HI/LO, stall behaviour and asynchronous reset.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.start  = 1'b0;
        bus.op     = MD_MFLO;
    endtask

    task automatic read_reg(input logic [2:0] o, output logic [31:0] v);
        bus.op = o;
        #1;
        v = bus.rdata;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset        = 1'b0;
        bus.md_use_D = 1'b1;
        bus.start    = 1'b1;
        bus.op       = MD_MULT;
        bus.rs_val   = 32'd3;
        bus.rt_val   = 32'd4;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.stall_D !== 1'b1) begin
            failures++;
            $display("FAIL reset_stall_arith: got %b want 1", bus.stall_D);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (bus.stall_D !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall_mfhi: got %b want 0", bus.stall_D);
        end
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL reset_hi: got %h want 00000000", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL reset_lo: got %h want 00000000", v);
        end
        bus.start    = 1'b0;
        bus.md_use_D = 1'b0;
        reset        = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [31:0] v;
        int          n;
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL mult_hi_early: got %h want 00000000", v);
        end
        count_busy(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL mult_busy_cycles: got %0d want 5", n);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mult_hi: got %h want ffffffff", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_lo: got %h want fffffffe", v);
        end
    endtask

    task automatic test_multu();
        logic [31:0] v;
        int          n;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL multu_busy_cycles: got %0d want 5", n);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_hi: got %h want 00000001", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_lo: got %h want fffffffe", v);
        end
    endtask

    task automatic test_div();
        logic [31:0] v;
        int          n;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL div_busy_cycles: got %0d want 10", n);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_lo: got %h want fffffffd", v);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_hi: got %h want ffffffff", v);
        end

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_ovf_lo: got %h want 80000000", v);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL div_ovf_hi: got %h want 00000000", v);
        end

        issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'h7FFF_FFFC) begin
            failures++;
            $display("FAIL divu_lo: got %h want 7ffffffc", v);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            failures++;
            $display("FAIL divu_hi: got %h want 00000001", v);
        end
    endtask

    task automatic test_move_and_div_zero();
        logic [31:0] v;
        int          n;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_busy: got %b want 0", bus.busy);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            failures++;
            $display("FAIL mthi_value: got %h want 00001234", v);
        end

        issue(MD_DIVU, 32'd7, 32'd0);
        count_busy(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL divu_zero_busy: got %0d want 10", n);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            failures++;
            $display("FAIL divu_zero_hi: got %h want 00001234", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL divu_zero_lo: got %h want 00000000", v);
        end

        issue(MD_MTLO, 32'h0000_5678, 32'd0);
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'h0000_5678) begin
            failures++;
            $display("FAIL mtlo_value: got %h want 00005678", v);
        end

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
        count_busy(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL div_zero_busy: got %0d want 10", n);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            failures++;
            $display("FAIL div_zero_hi: got %h want 00001234", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'h0000_5678) begin
            failures++;
            $display("FAIL div_zero_lo: got %h want 00005678", v);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        bus.md_use_D = 1'b1;
        bus.start    = 1'b1;
        bus.op       = MD_MULT;
        bus.rs_val   = 32'hFFFF_0000;
        bus.rt_val   = 32'h0001_0000;
        #1;
        checks++;
        if (bus.stall_D !== 1'b1) begin
            failures++;
            $display("FAIL stall_issue: got %b want 1", bus.stall_D);
        end
        tick();
        bus.start = 1'b0;
        bus.op    = MD_MFLO;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.stall_D !== 1'b1) begin
                failures++;
                $display("FAIL stall_busy_c%0d: got busy=%b stall=%b want 1/1", c, bus.busy, bus.stall_D);
            end
            if (c == 3) begin
                bus.start  = 1'b1;
                bus.op     = MD_DIV;
                bus.rs_val = 32'd100;
                bus.rt_val = 32'd7;
            end
            tick();
            bus.start = 1'b0;
            bus.op    = MD_MFLO;
        end
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall_D !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got busy=%b stall=%b want 0/0", bus.busy, bus.stall_D);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL b2b_mult_hi: got %h want ffffffff", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL b2b_mult_lo: got %h want 00000000", v);
        end
        bus.md_use_D = 1'b0;
        repeat (12) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored_busy: got %b want 0", bus.busy);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL b2b_ignored_lo: got %h want 00000000", v);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] v;
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midflight_busy_c4: got %b want 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset_busy: got %b want 0", bus.busy);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midflight_reset_hi: got %h want 00000000", v);
        end
        tick();
        reset = 1'b1;
        repeat (15) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midflight_after_busy: got %b want 0", bus.busy);
        end
        read_reg(MD_MFHI, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midflight_after_hi: got %h want 00000000", v);
        end
        read_reg(MD_MFLO, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL midflight_after_lo: got %h want 00000000", v);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = MD_MFLO;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.md_use_D = 1'b0;

        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_move_and_div_zero();
        test_back_to_back();
        test_reset_midflight();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
